sprite_scan_reader: RTL and testbench
=====================================

// Module: sprite_scan_reader
// PURPOSE
//  Display-side reader for the sprite memory interface (ram_addr_x/ram_addr_y -> ram_data).
//  Generates 640x480@60 VGA timing from the system clock.
//  Issues sprite coordinates for pixels inside a placed, optionally scaled sprite window.
//  Samples the returned 16-bit word and drives 4-bit RGB plus syncs.
//  Emits a per-frame pulse so animation steppers can advance frame-synchronously.
// PARAMETERS
//  PIX_DIV      4        clk cycles per pixel (100 MHz -> 25 MHz); >=2
//  H_ACTIVE     640      visible pixels per line
//  H_FP/H_SYNC/H_BP  16/96/48   horizontal porch/sync/porch, in pixels
//  V_ACTIVE     480      visible lines
//  V_FP/V_SYNC/V_BP  10/2/33    vertical porch/sync/porch, in lines
//  ORG_X        256      screen x of sprite top-left
//  ORG_Y        176      screen y of sprite top-left
//  SPR_W        128      sprite width in sprite pixels (<=256)
//  SPR_H        128      sprite height in sprite pixels (<=256)
//  SCALE_SHIFT  0        sprite magnified by 2**SCALE_SHIFT on screen
//  BG_COLOR     12'h000  RGB444 shown in active area outside sprite
//  KEY_COLOR    16'h0F0F transparent key (used only with SPRITE_KEY_EN)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  ram_addr_x   out  8   sprite column requested
//  ram_addr_y   out  8   sprite row requested
//  ram_data     in   16  sprite word, combinational from address; RGB444 in [11:0], [15:12] ignored
//  vga_r/g/b    out  4   colour channels
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  frame_start  out  1   one-clk pulse at start of each frame
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: div, h_cnt, v_cnt = 0; vga_r/g/b = 0; hsync = vsync = 1; frame_start = 0; ram_addr_x/y = 0.
//  Pixel tick: div counts 0..PIX_DIV-1 and wraps; pix_tick = (div == PIX_DIV-1).
//    First tick occurs PIX_DIV clks after reset release.
//  Counters (advance on pix_tick only): H_TOTAL = 800, V_TOTAL = 525.
//    h_cnt wraps 799 -> 0. v_cnt increments on h wrap and wraps 524 -> 0.
//  Window: in_spr = ORG_X <= h_cnt < ORG_X + (SPR_W << SCALE_SHIFT),
//    and likewise for v_cnt with ORG_Y/SPR_H. Compare at >= 11 bits; no overflow.
//  Address: combinational from registered counters; stable for the whole pixel period.
//    ram_addr_x = ((h_cnt - ORG_X) >> SCALE_SHIFT)[7:0]; ram_addr_y uses v_cnt/ORG_Y.
//    Outside the window: both addresses = 0.
//  Sample stage, one register updated on pix_tick:
//    active = (h_cnt < 640) && (v_cnt < 480).
//    colour = active && in_spr ? ram_data[11:0] : active ? BG_COLOR : 12'h000.
//    hsync_n = !(656 <= h_cnt < 752); vsync_n = !(490 <= v_cnt < 492); both registered in the same stage.
//  Latency: exactly one pixel period from counter position to rgb/sync outputs. Colour and syncs are always aligned.
//  Blanking: rgb are 0 whenever the sampled position is outside the active area.
//  frame_start = 1 for one clk when pix_tick && h_cnt == 799 && v_cnt == 524; else 0.
//  Reset mid-frame: all state returns to reset values immediately (async).
//    Scan restarts at (0,0); no partial line completes.
// CONFIGURATION
//  SPRITE_KEY_EN defined: a sprite pixel with ram_data == KEY_COLOR (all 16 bits) outputs BG_COLOR.
//    Outputs are otherwise identical.
//  SPRITE_KEY_EN undefined: no compare logic; every sprite pixel shows ram_data[11:0]; KEY_COLOR unused.
// TESTING
//  T1 reset: assert rst mid-line -> same clk rgb=0, hsync=vsync=1, frame_start=0, addrs=0.
//    Release -> first pix_tick after 4 clks.
//  T2 timing: free run one frame -> hsync low 96 px every 800 px, starting at registered h=657.
//    vsync low 2 lines every 525 lines.
//  T3 frame: count clks between frame_start pulses -> 1,680,000. Each pulse is exactly one clk wide.
//  T4 mapping: memory model returns {x,y} -> at h=256,v=176 addr=(0,0); at h=383,v=303 addr=(127,127).
//    At h=384 addr=(0,0) and output = BG_COLOR one pixel later.
//  T5 scale: SCALE_SHIFT=1 -> h=256 and h=257 both give ram_addr_x=0; h=258 gives 1; window ends at h=512.
//  T6 key: SPRITE_KEY_EN, ram_data=16'h0F0F in window -> BG_COLOR.
//    ram_data=16'h1F0F -> rgb=F/0/F. Without the macro, 16'h0F0F shows rgb=F/0/F.

Source files
------------

// File: rtl/sprite_scan_if.sv
// Sprite memory and VGA output bundle for sprite_scan_reader.
// master = display reader, slave = sprite memory / monitor side.
interface sprite_scan_if;
  logic [7:0]  ram_addr_x;
  logic [7:0]  ram_addr_y;
  logic [15:0] ram_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output ram_addr_x, ram_addr_y,
    output vga_r, vga_g, vga_b,
    output hsync, vsync, frame_start,
    input  ram_data
  );

  modport slave (
    input  ram_addr_x, ram_addr_y,
    input  vga_r, vga_g, vga_b,
    input  hsync, vsync, frame_start,
    output ram_data
  );
endinterface

// File: rtl/sprite_scan_reader.sv
// VGA scan generator that reads a placed, scaled sprite from memory.
// Optional SPRITE_KEY_EN: sprite words equal to KEY_COLOR show BG_COLOR.
module sprite_scan_reader #(
  parameter int unsigned PIX_DIV     = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned ORG_X       = 256,
  parameter int unsigned ORG_Y       = 176,
  parameter int unsigned SPR_W       = 128,
  parameter int unsigned SPR_H       = 128,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter logic [15:0] KEY_COLOR   = 16'h0F0F
) (
  input logic           clk,
  input logic           rst,
  sprite_scan_if.master m_if
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW = $clog2(PIX_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [11:0] H_LAST = 12'(HT - 1);
  localparam logic [11:0] V_LAST = 12'(VT - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_LO  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_HI  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_LO  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_HI  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] X_LO   = 12'(ORG_X);
  localparam logic [11:0] X_HI   = 12'(ORG_X + (SPR_W << SCALE_SHIFT));
  localparam logic [11:0] Y_LO   = 12'(ORG_Y);
  localparam logic [11:0] Y_HI   = 12'(ORG_Y + (SPR_H << SCALE_SHIFT));

  logic [DW-1:0] r_div;
  logic [11:0]   r_h;
  logic [11:0]   r_v;
  logic [11:0]   r_rgb;
  logic          r_hs;
  logic          r_vs;

  logic        w_tick;
  logic        w_hend;
  logic        w_vend;
  logic        w_inx;
  logic        w_iny;
  logic        w_in;
  logic        w_act;
  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic [11:0] w_pix;
  logic [11:0] w_rgb;

  assign w_tick = (r_div == DIV_LAST);
  assign w_hend = (r_h == H_LAST);
  assign w_vend = (r_v == V_LAST);

  assign w_inx = (r_h >= X_LO) && (r_h < X_HI);
  assign w_iny = (r_v >= Y_LO) && (r_v < Y_HI);
  assign w_in  = w_inx && w_iny;
  assign w_act = (r_h < H_ACT) && (r_v < V_ACT);

  assign w_dx = r_h - X_LO;
  assign w_dy = r_v - Y_LO;

  assign m_if.ram_addr_x = w_in ? 8'(w_dx >> SCALE_SHIFT) : 8'h00;
  assign m_if.ram_addr_y = w_in ? 8'(w_dy >> SCALE_SHIFT) : 8'h00;

`ifdef SPRITE_KEY_EN
  assign w_pix = (m_if.ram_data == KEY_COLOR) ? BG_COLOR
                                              : m_if.ram_data[11:0];
`else
  logic w_unused_key;
  assign w_unused_key = ^{m_if.ram_data[15:12], KEY_COLOR};
  assign w_pix = m_if.ram_data[11:0];
`endif

  always_comb begin
    w_rgb = 12'h000;
    if (w_act) begin
      w_rgb = w_in ? w_pix : BG_COLOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_h <= w_hend ? 12'd0 : r_h + 12'd1;
        if (w_hend) begin
          r_v <= w_vend ? 12'd0 : r_v + 12'd1;
        end
      end
    end
  end

  // Colour and syncs share one stage so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= 12'h000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (w_tick) begin
      r_rgb <= w_rgb;
      r_hs  <= !((r_h >= HS_LO) && (r_h < HS_HI));
      r_vs  <= !((r_v >= VS_LO) && (r_v < VS_HI));
    end
  end

  assign m_if.vga_r       = r_rgb[11:8];
  assign m_if.vga_g       = r_rgb[7:4];
  assign m_if.vga_b       = r_rgb[3:0];
  assign m_if.hsync       = r_hs;
  assign m_if.vsync       = r_vs;
  assign m_if.frame_start = w_tick && w_hend && w_vend;

endmodule

// File: tb/tb_sprite_scan_reader.sv
// Scoreboard bench for sprite_scan_reader on a shrunken, scaled raster.
// Expected pixels come from a pixel-index model of the scan.
module tb_sprite_scan_reader;

  localparam int PD = 4;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int OX = 10, OY = 5, SW = 12, SH = 8, SS = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [11:0] BG  = 12'h5A3;
  localparam logic [15:0] KEY = 16'h0F0F;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sprite_scan_if bus ();

  logic [15:0] mem [0:15][0:15];

  int errs = 0;
  int checks = 0;
  int c = 0;
  int last_fs = -1;
  bit pend = 1'b0;
  logic [13:0] q [$];

  sprite_scan_reader #(
    .PIX_DIV(PD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ORG_X(OX), .ORG_Y(OY), .SPR_W(SW), .SPR_H(SH),
    .SCALE_SHIFT(SS), .BG_COLOR(BG), .KEY_COLOR(KEY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_if(bus)
  );

  assign bus.ram_data = mem[bus.ram_addr_y[3:0]][bus.ram_addr_x[3:0]];

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit in_win(int h, int v);
    return h >= OX && h < OX + SW * (1 << SS) &&
           v >= OY && v < OY + SH * (1 << SS);
  endfunction

  function automatic logic [11:0] spr_pix(int sx, int sy);
    logic [15:0] d;
    d = mem[sy][sx];
`ifdef SPRITE_KEY_EN
    if (d == KEY) return BG;
`endif
    return d[11:0];
  endfunction

  function automatic logic [13:0] exp_out(int h, int v);
    logic [11:0] rgb;
    bit act, hs, vs;
    act = h < HA && v < VA;
    if (act && in_win(h, v))
      rgb = spr_pix((h - OX) / (1 << SS), (v - OY) / (1 << SS));
    else if (act)
      rgb = BG;
    else
      rgb = 12'h000;
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    return {rgb, hs, vs};
  endfunction

  // Clocks seen since reset release.
  always @(posedge clk) begin
    if (rst) c <= 0;
    else     c <= c + 1;
  end

  // Stimulus side: address/pulse checks and expected-pixel pushes.
  always @(negedge clk) begin
    int p, h, v;
    bit tk;
    if (!rst) begin
      p  = c / PD;
      h  = p % HT;
      v  = (p / HT) % VT;
      tk = ((c + 1) % PD) == 0;
      chk("addr_x", 32'(bus.ram_addr_x),
          in_win(h, v) ? 32'((h - OX) / (1 << SS)) : 32'd0);
      chk("addr_y", 32'(bus.ram_addr_y),
          in_win(h, v) ? 32'((v - OY) / (1 << SS)) : 32'd0);
      chk("frame_start", 32'(bus.frame_start),
          32'(tk && h == HT - 1 && v == VT - 1));
      if (bus.frame_start === 1'b1) begin
        if (last_fs >= 0)
          chk("fs_period", 32'(c - last_fs), 32'(FRAME * PD));
        last_fs = c;
      end
      if (tk) begin
        q.push_back(exp_out(h, v));
        pend = 1'b1;
      end
    end
  end

  // Monitor: after each pixel tick compare the registered outputs.
  always @(posedge clk) begin
    logic [13:0] e;
    if (pend) begin
      pend = 1'b0;
      #1;
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL scoreboard: got output with empty queue");
      end else begin
        e = q.pop_front();
        chk("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(e[13:2]));
        chk("hsync", 32'(bus.hsync), 32'(e[1]));
        chk("vsync", 32'(bus.vsync), 32'(e[0]));
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
    chk({tag, "_hs"}, 32'(bus.hsync), 32'd1);
    chk({tag, "_vs"}, 32'(bus.vsync), 32'd1);
    chk({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
    chk({tag, "_ax"}, 32'(bus.ram_addr_x), 32'd0);
    chk({tag, "_ay"}, 32'(bus.ram_addr_y), 32'd0);
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    q.delete();
    pend = 1'b0;
    last_fs = -1;
    rst = 1'b0;
  endtask

  // Run until pixel pix is held, then reset asynchronously mid-pixel.
  task automatic reset_at(input int pix, input string tag);
    repeat (pix * PD + 2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    reset_checks(tag);
    release_rst();
  endtask

  initial begin
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        mem[y][x] = 16'($urandom);
        if ($urandom_range(0, 4) == 0) mem[y][x] = KEY;
      end
    end
    mem[2][4] = 16'h1F0F;
    mem[0][0] = KEY;
    mem[SH-1][SW-1] = 16'($urandom) | 16'h0111;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("rst_init");
    release_rst();

    reset_at(2 * FRAME + 10 * HT + 20, "rst_win");
    reset_at(FRAME + (VA + VF) * HT + HA + HF + 2, "rst_sync");

    repeat ((FRAME + 100) * PD) @(posedge clk);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
